axi_lite_sram: RTL

//   AXI4-Lite slave memory that answers the core's instruction-fetch and load/store masters.

---
 rtl/sram_pkg.sv | 23 ++
 rtl/axi_lite_sram_lfsr16.sv | 17 +
 rtl/axi_lite_sram.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared response codes, FSM state types and sizing helper for the AXI4-Lite SRAM slave.
package sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_RESP
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT,
        WR_RESP
    } wr_state_e;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/axi_lite_sram_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), loaded with seed while reset is low.
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= seed;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
        end
    end

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave SRAM with independent read and write engines and fixed response latency.
// Define SRAM_RAND_DELAY_EN to draw a per-transaction latency of 1..8 cycles from an LFSR instead.
module axi_lite_sram
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 32768,
    parameter int unsigned LATENCY     = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    rd_state_e   rd_state;
    wr_state_e   wr_state;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] rd_cnt, wr_cnt;
    logic [31:0] lat_m1;

    logic [31:0]      rd_word, wr_word;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             rd_fault, wr_fault, wr_commit;

`ifdef SRAM_RAND_DELAY_EN
    logic [15:0] lfsr_q;
    logic        lfsr_unused;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    assign lat_m1      = {29'd0, lfsr_q[2:0]};
    assign lfsr_unused = ^lfsr_q[15:3];
`else
    assign lat_m1 = 32'(LATENCY - 1);
`endif

    // Subtraction is only trusted when addr >= BASE_ADDR; the compare guards the wrap case.
    assign rd_word  = (rd_addr - BASE_ADDR) >> 2;
    assign wr_word  = (wr_addr - BASE_ADDR) >> 2;
    assign rd_fault = (rd_addr < BASE_ADDR) || (rd_word >= DEPTH_WORDS);
    assign wr_fault = (wr_addr < BASE_ADDR) || (wr_word >= DEPTH_WORDS);
    assign rd_idx   = rd_word[IDX_W-1:0];
    assign wr_idx   = wr_word[IDX_W-1:0];

    assign wr_commit = rst && (wr_state == WR_WAIT) && (wr_cnt == '0) && !wr_fault;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state <= RD_IDLE;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            rd_cnt   <= '0;
            rd_addr  <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (arvalid) begin
                        rd_addr  <= araddr;
                        rd_cnt   <= lat_m1;
                        arready  <= 1'b0;
                        rd_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_cnt == '0) begin
                        rvalid   <= 1'b1;
                        rd_state <= RD_RESP;
                        if (rd_fault) begin
                            rdata <= '0;
                            rresp <= RESP_SLVERR;
                        end else begin
                            rdata <= mem[rd_idx];
                            rresp <= RESP_OKAY;
                        end
                    end else begin
                        rd_cnt <= rd_cnt - 1;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        rvalid   <= 1'b0;
                        arready  <= 1'b1;
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_state <= WR_IDLE;
            awready  <= 1'b1;
            wready   <= 1'b1;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            wr_cnt   <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_strb  <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    // A dropped ready marks that channel's payload as already held.
                    if (awvalid && awready) begin
                        wr_addr <= awaddr;
                        awready <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wr_data <= wdata;
                        wr_strb <= wstrb;
                        wready  <= 1'b0;
                    end
                    if ((!awready || awvalid) && (!wready || wvalid)) begin
                        wr_cnt   <= lat_m1;
                        wr_state <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (wr_cnt == '0) begin
                        bvalid   <= 1'b1;
                        bresp    <= wr_fault ? RESP_SLVERR : RESP_OKAY;
                        wr_state <= WR_RESP;
                    end else begin
                        wr_cnt <= wr_cnt - 1;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wready   <= 1'b1;
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule
